store_align_unit: RTL
=====================

Name: store_align_unit

Overview:
Store-side counterpart of the load data extender. It sits between the MEM-stage store request and the word-addressed data memory port. It converts a byte address, store type and register data into word-aligned write beats with shifted data and byte enables. Misaligned SH/SW stores that cross a word boundary are split into two sequential memory beats under a valid/ready handshake, and the unit reports busy/done back to the hazard unit.

Parameters:
ALLOW_MISALIGNED, 1, when 0 any misaligned SH/SW raises err and performs no write
ADDR_W, 32, byte-address width

Ports:
CPU_CLK  in  1  core clock, all state on rising edge
CPU_RST_N  in  1  asynchronous active-low reset
req_valid  in  1  store request present
req_ready  out  1  unit can accept a request; equals (state==IDLE)
req_type  in  2  store type: ST_SB=2'b00, ST_SH=2'b01, ST_SW=2'b10, 2'b11 illegal
req_addr  in  ADDR_W  byte address
req_data  in  32  rs2 value; the low bytes are used
mem_valid  out  1  write beat valid
mem_ready  in  1  memory accepts beat
mem_addr  out  ADDR_W  word-aligned byte address, [1:0]=0
mem_wdata  out  32  lane-shifted write data
mem_be  out  4  byte enables, bit i = byte lane i
busy  out  1  high from accept until final beat handshake (stall request)
done  out  1  one-cycle pulse after the last beat completes
err  out  1  one-cycle pulse on illegal type or disallowed misalignment

Behaviour:
- Reset (async, CPU_RST_N=0): state=IDLE; mem_valid, mem_addr, mem_wdata, mem_be, busy, done, err all 0; req_ready=1. Reset mid-transaction abandons it. A beat already handshaken stays written; nothing is rolled back.
- Accept on the rising edge with req_valid && req_ready. Latch off=req_addr[1:0] and base=req_addr with [1:0] cleared.
- Mask: SB=4'b0001, SH=4'b0011, SW=4'b1111.
- Shifted mask m8 = {4'b0,mask} << off (8 bits). Shifted data d64 = {32'b0,req_data} << (8*off) (64 bits).
- Beat0: addr=base, be=m8[3:0], wdata=d64[31:0].
- Beat1 is needed iff m8[7:4]!=0: addr=base+4 (mod 2^ADDR_W, so it wraps from 0xFFFFFFFC to 0), be=m8[7:4], wdata=d64[63:32].
- Illegal type (2'b11), or misaligned SH/SW with ALLOW_MISALIGNED=0: accept, pulse err in the next cycle, no beats, stay IDLE. done stays 0.
- FSM: IDLE -> BEAT0 on accept (legal). BEAT0 -> BEAT1 on mem_ready if beat1 is needed, else -> IDLE with done. BEAT1 -> IDLE on mem_ready with done.
- mem_valid, mem_addr, mem_wdata and mem_be are registered. They are valid in the cycle after entering BEAT0/BEAT1 and held stable until mem_ready. mem_valid never drops without a handshake, except on reset.
- On a beat0 handshake that needs beat1, beat1 presents on the next cycle with no bubble.
- Latency with mem_ready tied high: accept at edge N. Beat0 is valid in cycle N..N+1 and handshakes at edge N+1. Single beat: done high in cycle after N+1, and req_ready high in that same cycle, so back-to-back stores lose no cycle. Split store: done one cycle later.
- busy is high from accept through the final handshake edge.
- When not in BEAT states, mem_be=0 and mem_wdata holds its last value (don't-care).
- Simultaneous req_valid while busy: ignored (req_ready=0). The requester must hold the request.

Decomposition:
- Parameters.v gains ST_SB/ST_SH/ST_SW/ST_ILL codes and the FSM state encodings S_IDLE/S_BEAT0/S_BEAT1.
- One natural combinational sub-module, store_lane_shift: (type, off, data) -> m8, d64, need_beat1, misaligned. The FSM stays in store_align_unit.

Test Plan:
- SB addr=0x103 data=0xAABBCCDD, mem_ready=1 -> one beat: addr 0x100, be=1000, wdata=0xDD000000; done 2 cycles after accept.
- SW addr=0x202 data=0x11223344 -> beat0 addr 0x200 be=1100 wdata=0x33440000; beat1 addr 0x204 be=0011 wdata=0x00001122; done once.
- SH addr=0x13 data=0xBEEF with mem_ready low 3 cycles on each beat -> outputs stable while stalled; beat0 0x10 be=1000 wdata=0xEF000000; beat1 0x14 be=0001 wdata=0x000000BE.
- SW addr=0xFFFFFFFE -> beat1 addr wraps to 0x00000000, be=0011.
- req_type=2'b11, and separately SH addr=0x1 with ALLOW_MISALIGNED=0 -> err pulse, mem_valid never asserts, done=0.
- CPU_RST_N asserted between the two beats of a split SW -> immediate IDLE, mem_valid=0, req_ready=1; the next SB completes normally.

Source files
------------

// File: rtl/store_align_unit_pkg.sv
// Shared definitions for the store alignment unit.
//   st_type_e : store type codes seen on req_type
//   state_e   : beat sequencer state encoding
//   st_mask   : unshifted byte mask for a store type
package store_align_unit_pkg;

    typedef enum logic [1:0] {
        ST_SB  = 2'b00,
        ST_SH  = 2'b01,
        ST_SW  = 2'b10,
        ST_ILL = 2'b11
    } st_type_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BEAT0 = 2'b01,
        S_BEAT1 = 2'b10
    } state_e;

    function automatic logic [3:0] st_mask(st_type_e t);
        case (t)
            ST_SB:   st_mask = 4'b0001;
            ST_SH:   st_mask = 4'b0011;
            ST_SW:   st_mask = 4'b1111;
            default: st_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_align_unit_lane_shift.sv
// Combinational lane shifter for stores.
//   type_i       : store type
//   off_i        : byte offset within the word
//   data_i       : register data (low bytes used)
//   m8_o         : byte mask shifted across two words (low nibble = beat0)
//   d64_o        : data shifted across two words (low word = beat0)
//   need_beat1_o : store spills into the next word
//   misalign_o   : SH on odd offset or SW on non-zero offset
module store_lane_shift
    import store_align_unit_pkg::*;
(
    input  st_type_e    type_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [7:0]  m8_o,
    output logic [63:0] d64_o,
    output logic        need_beat1_o,
    output logic        misalign_o
);

    assign m8_o         = {4'b0000, st_mask(type_i)} << off_i;
    assign d64_o        = {32'b0, data_i} << {off_i, 3'b000};
    assign need_beat1_o = |m8_o[7:4];
    assign misalign_o   = ((type_i == ST_SH) && off_i[0]) ||
                          ((type_i == ST_SW) && (off_i != 2'b00));

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: turns a byte-addressed store into one or two
// word-aligned write beats with byte enables.
//   CPU_CLK, CPU_RST_N           : clock, async active-low reset
//   req_valid/req_ready          : store request handshake
//   req_type/req_addr/req_data   : store type, byte address, rs2 data
//   mem_valid/mem_ready          : write beat handshake
//   mem_addr/mem_wdata/mem_be    : registered beat payload
//   busy                         : request in flight (stall)
//   done                         : pulse after final beat handshake
//   err                          : pulse after an illegal/disallowed request
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Second-beat payload captured at accept so the request can go away.
    logic              need1_q, need1_d;
    logic [ADDR_W-1:0] b1_addr_q, b1_addr_d;
    logic [31:0]       b1_wdata_q, b1_wdata_d;
    logic [3:0]        b1_be_q, b1_be_d;

    logic [7:0]        m8;
    logic [63:0]       d64;
    logic              need_beat1;
    logic              misalign;
    logic              bad_req;
    logic [ADDR_W-1:0] base;

    store_lane_shift u_shift (
        .type_i       (st_type_e'(req_type)),
        .off_i        (req_addr[1:0]),
        .data_i       (req_data),
        .m8_o         (m8),
        .d64_o        (d64),
        .need_beat1_o (need_beat1),
        .misalign_o   (misalign)
    );

    assign base    = {req_addr[ADDR_W-1:2], 2'b00};
    assign bad_req = (st_type_e'(req_type) == ST_ILL) || (!ALLOW_MISALIGNED && misalign);

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        need1_d     = need1_q;
        b1_addr_d   = b1_addr_q;
        b1_wdata_d  = b1_wdata_q;
        b1_be_d     = b1_be_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_BEAT0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = base;
                        mem_be_d    = m8[3:0];
                        mem_wdata_d = d64[31:0];
                        busy_d      = 1'b1;
                        need1_d     = need_beat1;
                        b1_addr_d   = base + ADDR_W'(4);  // wraps at top of space
                        b1_be_d     = m8[7:4];
                        b1_wdata_d  = d64[63:32];
                    end
                end
            end
            S_BEAT0: begin
                if (mem_ready) begin
                    if (need1_q) begin
                        // Present the second beat immediately, no bubble.
                        state_d     = S_BEAT1;
                        mem_addr_d  = b1_addr_q;
                        mem_be_d    = b1_be_q;
                        mem_wdata_d = b1_wdata_q;
                    end else begin
                        state_d     = S_IDLE;
                        mem_valid_d = 1'b0;
                        mem_be_d    = 4'b0000;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_ready) begin
                    state_d     = S_IDLE;
                    mem_valid_d = 1'b0;
                    mem_be_d    = 4'b0000;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q     <= S_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            need1_q     <= 1'b0;
            b1_addr_q   <= '0;
            b1_wdata_q  <= '0;
            b1_be_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            need1_q     <= need1_d;
            b1_addr_q   <= b1_addr_d;
            b1_wdata_q  <= b1_wdata_d;
            b1_be_q     <= b1_be_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
